// File: rtl/sparse_tile_encoder.sv
// Streams a dense W_ROW x W_COL weight tile column by column and builds the per-PE
// (w, p, z) compressed tile. Optional tile_nnz output: define SPARSE_TILE_ENCODER_NNZ_EN.
module sparse_tile_encoder #(
    parameter int PE_NUM = 4,
    parameter int W_ROW  = 16,
    parameter int W_COL  = 8,
    parameter int BW_W   = 8,
    parameter int BW_P   = 7,
    parameter int BW_Z   = 3,
    localparam int RPP   = W_ROW / PE_NUM,
    localparam int SLOTS = RPP * W_COL
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                col_valid,
    output logic                                col_ready,
    input  logic [W_ROW*BW_W-1:0]               col_data,
    output logic                                tile_valid,
    input  logic                                tile_ready,
    output logic [PE_NUM*SLOTS*BW_W-1:0]        enc_w,
    output logic [PE_NUM*(W_COL+1)*BW_P-1:0]    enc_p,
    output logic [PE_NUM*SLOTS*BW_Z-1:0]        enc_z
`ifdef SPARSE_TILE_ENCODER_NNZ_EN
    ,
    output logic [$clog2(W_ROW*W_COL+1)-1:0]    tile_nnz
`endif
);

    localparam int SW = $clog2(SLOTS);
    localparam int CW = $clog2(W_COL + 1);

    typedef enum logic {ACCEPT, HOLD} state_t;
    state_t state_q, state_d;

    logic [CW-1:0]   col_idx;
    logic [BW_P-1:0] cnt     [PE_NUM];
    logic [BW_W-1:0] w_mem   [PE_NUM][SLOTS];
    logic [BW_Z-1:0] z_mem   [PE_NUM][SLOTS];
    logic [BW_P-1:0] p_mem   [PE_NUM][W_COL+1];

    logic [BW_W-1:0] word    [PE_NUM][RPP];
    logic            nz      [PE_NUM][RPP];
    logic [SW-1:0]   slot    [PE_NUM][RPP];
    logic [BW_P-1:0] col_nnz [PE_NUM];
    logic            col_fire, tile_fire, last_col;

    assign last_col = (col_idx == CW'(W_COL - 1));

    always_comb begin
        state_d    = state_q;
        col_ready  = 1'b0;
        tile_valid = 1'b0;
        col_fire   = 1'b0;
        tile_fire  = 1'b0;
        case (state_q)
            ACCEPT: begin
                col_ready = ~reset;
                col_fire  = col_valid & ~reset;
                if (col_fire && last_col) state_d = HOLD;
            end
            HOLD: begin
                tile_valid = 1'b1;
                tile_fire  = tile_ready;
                if (tile_ready) state_d = ACCEPT;
            end
            default: state_d = ACCEPT;
        endcase
    end

    // Each nonzero lands at cnt plus the number of nonzeros above it in the same PE slice.
    always_comb begin
        logic [BW_P-1:0] run;
        for (int unsigned k = 0; k < PE_NUM; k++) begin
            run = '0;
            for (int unsigned j = 0; j < RPP; j++) begin
                word[k][j] = col_data[(k*RPP+j)*BW_W +: BW_W];
                nz[k][j]   = (word[k][j] != '0);
                slot[k][j] = cnt[k][SW-1:0] + run[SW-1:0];
                run        = run + BW_P'(nz[k][j]);
            end
            col_nnz[k] = run;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ACCEPT;
            col_idx <= '0;
            cnt     <= '{default: '0};
            w_mem   <= '{default: '{default: '0}};
            z_mem   <= '{default: '{default: '0}};
            p_mem   <= '{default: '{default: '0}};
        end else begin
            state_q <= state_d;
            if (col_fire) begin
                for (int unsigned k = 0; k < PE_NUM; k++) begin
                    p_mem[k][col_idx] <= cnt[k];
                    for (int unsigned j = 0; j < RPP; j++) begin
                        if (nz[k][j]) begin
                            w_mem[k][slot[k][j]] <= word[k][j];
                            z_mem[k][slot[k][j]] <= BW_Z'(j);
                        end
                    end
                    cnt[k] <= cnt[k] + col_nnz[k];
                    if (last_col) p_mem[k][W_COL] <= cnt[k] + col_nnz[k];
                end
                col_idx <= last_col ? '0 : col_idx + 1'b1;
            end else if (tile_fire) begin
                col_idx <= '0;
                cnt     <= '{default: '0};
                w_mem   <= '{default: '{default: '0}};
                z_mem   <= '{default: '{default: '0}};
                p_mem   <= '{default: '{default: '0}};
            end
        end
    end

    always_comb begin
        enc_w = '0;
        enc_z = '0;
        enc_p = '0;
        for (int unsigned k = 0; k < PE_NUM; k++) begin
            for (int unsigned s = 0; s < SLOTS; s++) begin
                enc_w[(k*SLOTS+s)*BW_W +: BW_W] = w_mem[k][s];
                enc_z[(k*SLOTS+s)*BW_Z +: BW_Z] = z_mem[k][s];
            end
            for (int unsigned c = 0; c <= W_COL; c++) begin
                enc_p[(k*(W_COL+1)+c)*BW_P +: BW_P] = p_mem[k][c];
            end
        end
    end

`ifdef SPARSE_TILE_ENCODER_NNZ_EN
    localparam int NW = $clog2(W_ROW*W_COL+1);
    always_comb begin
        tile_nnz = '0;
        if (state_q == HOLD) begin
            for (int unsigned k = 0; k < PE_NUM; k++) begin
                tile_nnz = tile_nnz + NW'(cnt[k]);
            end
        end
    end
`endif

endmodule
